// File: rtl/memory_cycle_ft_pkg.sv
// Shared definitions for the memory-cycle stage: fault FSM encoding,
// word-offset within a byte address, default memory depth, W-stage bundle.
package memory_cycle_ft_pkg;

    typedef enum logic {
        HEALTHY = 1'b0,
        FAULTED = 1'b1
    } fault_state_e;

    // Number of byte-offset bits below the word index in a byte address.
    localparam int WORD_OFFSET = 2;

    localparam int DEFAULT_DEPTH = 1024;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic        reg_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic        parity_err;
    } mem_wb_t;

    // Even-parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/memory_cycle_ft_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Reads return the contents before any same-edge write (old data).
// Optional MEM_PARITY_EN: one stored even-parity bit per word, checked on read.
module memory_cycle_ft_data_memory
    import memory_cycle_ft_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 10
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              parity_mismatch
);

    logic [31:0] mem_q [DEPTH];

    // Store the word on the clock edge when the caller has qualified the write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

`ifdef MEM_PARITY_EN
    logic par_q [DEPTH];

    // Parity is written alongside its data word.
    always_ff @(posedge clk) begin
        if (we) begin
            par_q[addr] <= even_parity(wdata);
        end
    end

    assign parity_mismatch = (even_parity(rdata) != par_q[addr]);
`else
    assign parity_mismatch = 1'b0;
`endif

endmodule

// File: rtl/memory_cycle_ft.sv
// Pipeline M stage: data memory access, MEM/WB register and a fault-event
// monitor (BIST onset counter, first-onset timestamp, misaligned-store block).
// Optional build macro: MEM_PARITY_EN adds per-word parity and parity_err_W.
// Reset rst is synchronous and active-low.
module memory_cycle_ft
    import memory_cycle_ft_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             ResultSrcM,
    input  logic [4:0]       RD_M,
    input  logic [31:0]      PCPlus4M,
    input  logic [31:0]      WriteDataM,
    input  logic [31:0]      ALU_ResultM,
    input  logic             hardware_fault_flag_in,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic [4:0]       RD_W,
    output logic [31:0]      PCPlus4W,
    output logic [31:0]      ALU_ResultW,
    output logic [31:0]      ReadDataW,
    output logic             misalign_err,
    output logic             fault_state,
    output logic [CNT_W-1:0] fault_count,
    output logic [31:0]      fault_cycle,
    output logic             parity_err_W
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              mem_parity_mismatch;

    mem_wb_t           mem_wb_q, mem_wb_d;
    logic              misalign_err_q, misalign_err_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic              flag_prev_q, flag_prev_d;
    logic [CNT_W-1:0]  fault_count_q, fault_count_d;
    logic [31:0]       fault_cycle_q, fault_cycle_d;
    fault_state_e      state_q, state_d;
    logic              onset;
    logic              capture_first;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
    assign word_idx   = ALU_ResultM[WORD_OFFSET +: ADDR_W];
    assign misaligned = (ALU_ResultM[WORD_OFFSET-1:0] != '0);
    // Reset wins over any store presented in the same cycle.
    assign mem_we     = rst && MemWriteM && !misaligned;

    memory_cycle_ft_data_memory #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk            (clk),
        .we             (mem_we),
        .addr           (word_idx),
        .wdata          (WriteDataM),
        .rdata          (mem_rdata),
        .parity_mismatch(mem_parity_mismatch)
    );

    // MEM/WB contents: every cycle W takes M, zeroed while in reset.
    always_comb begin
        mem_wb_d = '0;
        if (rst) begin
            mem_wb_d.reg_write  = RegWriteM;
            mem_wb_d.result_src = ResultSrcM;
            mem_wb_d.rd         = RD_M;
            mem_wb_d.pc_plus4   = PCPlus4M;
            mem_wb_d.alu_result = ALU_ResultM;
            mem_wb_d.read_data  = mem_rdata;
            mem_wb_d.parity_err = ResultSrcM && mem_parity_mismatch;
        end
    end

    // Sticky misaligned-store flag, cleared only by reset.
    always_comb begin
        misalign_err_d = 1'b0;
        if (rst) begin
            misalign_err_d = misalign_err_q || (MemWriteM && misaligned);
        end
    end

    assign onset = hardware_fault_flag_in && !flag_prev_q;

    // Fault monitor datapath: cycle counter, edge detector, saturating count,
    // and the first-onset timestamp.
    always_comb begin
        cycle_cnt_d   = '0;
        flag_prev_d   = 1'b0;
        fault_count_d = '0;
        fault_cycle_d = '0;
        if (rst) begin
            cycle_cnt_d   = cycle_cnt_q + 32'd1;
            flag_prev_d   = hardware_fault_flag_in;
            fault_count_d = fault_count_q;
            if (onset && (fault_count_q != CNT_MAX)) begin
                fault_count_d = fault_count_q + CNT_W'(1);
            end
            fault_cycle_d = capture_first ? cycle_cnt_q : fault_cycle_q;
        end
    end

    // Fault FSM next state: first onset moves to FAULTED, which only reset leaves.
    always_comb begin
        state_d = state_q;
        if (!rst) begin
            state_d = HEALTHY;
        end else if ((state_q == HEALTHY) && onset) begin
            state_d = FAULTED;
        end
    end

    // Fault FSM outputs: exported state and the one-shot timestamp capture.
    always_comb begin
        fault_state   = state_q;
        capture_first = (state_q == HEALTHY) && onset;
    end

    // All stage state registers.
    always_ff @(posedge clk) begin
        mem_wb_q       <= mem_wb_d;
        misalign_err_q <= misalign_err_d;
        cycle_cnt_q    <= cycle_cnt_d;
        flag_prev_q    <= flag_prev_d;
        fault_count_q  <= fault_count_d;
        fault_cycle_q  <= fault_cycle_d;
        state_q        <= state_d;
    end

    assign RegWriteW    = mem_wb_q.reg_write;
    assign ResultSrcW   = mem_wb_q.result_src;
    assign RD_W         = mem_wb_q.rd;
    assign PCPlus4W     = mem_wb_q.pc_plus4;
    assign ALU_ResultW  = mem_wb_q.alu_result;
    assign ReadDataW    = mem_wb_q.read_data;
    assign parity_err_W = mem_wb_q.parity_err;
    assign misalign_err = misalign_err_q;
    assign fault_count  = fault_count_q;
    assign fault_cycle  = fault_cycle_q;

endmodule

// File: tb/tb_memory_cycle_ft.sv
// Bench for memory_cycle_ft: behavioural model (array memory, onset counter,
// timestamp) checked every cycle, plus literal expectations at directed points.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_memory_cycle_ft;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, RegWriteM, MemWriteM, ResultSrcM, hardware_fault_flag_in;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    logic        RegWriteW, ResultSrcW, misalign_err, fault_state, parity_err_W;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, fault_cycle;
    logic [7:0]  fault_count;

    logic        s_RegWriteW, s_ResultSrcW, s_misalign_err, s_fault_state, s_parity_err_W;
    logic [4:0]  s_RD_W;
    logic [31:0] s_PCPlus4W, s_ALU_ResultW, s_ReadDataW, s_fault_cycle;
    logic [1:0]  s_fault_count;

    memory_cycle_ft #(.DEPTH(DEPTH), .ADDR_W(10), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .hardware_fault_flag_in(hardware_fault_flag_in),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .misalign_err(misalign_err), .fault_state(fault_state),
        .fault_count(fault_count), .fault_cycle(fault_cycle),
        .parity_err_W(parity_err_W)
    );

    memory_cycle_ft #(.DEPTH(DEPTH), .ADDR_W(10), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .hardware_fault_flag_in(hardware_fault_flag_in),
        .RegWriteW(s_RegWriteW), .ResultSrcW(s_ResultSrcW), .RD_W(s_RD_W),
        .PCPlus4W(s_PCPlus4W), .ALU_ResultW(s_ALU_ResultW), .ReadDataW(s_ReadDataW),
        .misalign_err(s_misalign_err), .fault_state(s_fault_state),
        .fault_count(s_fault_count), .fault_cycle(s_fault_cycle),
        .parity_err_W(s_parity_err_W)
    );

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int m);
        return (v > m) ? 32'(m) : 32'(v);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [DEPTH];
    bit          mem_v [DEPTH];
    bit          par_bad [DEPTH];
    logic [31:0] cyc_m;
    bit          prev_m, faulted_m, mis_m, started;
    int          onsets_m;
    logic [31:0] fcyc_m;
    logic        e_rw, e_rs, e_perr;
    logic [4:0]  e_rd;
    logic [31:0] e_pc, e_alu, e_rdata;
    bit          e_rdata_v;

    initial begin
        started = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_v[i]   = 0;
            par_bad[i] = 0;
        end
    end

    always @(posedge clk) begin : model
        int idx;
        started = 1;
        if (!rst) begin
            e_rw = 0; e_rs = 0; e_rd = 0; e_pc = 0; e_alu = 0; e_rdata = 0;
            e_rdata_v = 1; e_perr = 0;
            cyc_m = 0; prev_m = 0; faulted_m = 0; mis_m = 0; onsets_m = 0; fcyc_m = 0;
        end else begin
            idx       = int'(ALU_ResultM[11:2]);
            e_rw      = RegWriteM;
            e_rs      = ResultSrcM;
            e_rd      = RD_M;
            e_pc      = PCPlus4M;
            e_alu     = ALU_ResultM;
            e_rdata   = mem_m[idx];
            e_rdata_v = mem_v[idx];
            e_perr    = ResultSrcM && par_bad[idx];
            if (MemWriteM) begin
                if (ALU_ResultM[1:0] == 2'b00) begin
                    mem_m[idx]   = WriteDataM;
                    mem_v[idx]   = 1;
                    par_bad[idx] = 0;
                end else begin
                    mis_m = 1;
                end
            end
            if (hardware_fault_flag_in && !prev_m) begin
                onsets_m++;
                if (!faulted_m) begin
                    faulted_m = 1;
                    fcyc_m    = cyc_m;
                end
            end
            prev_m = hardware_fault_flag_in;
            cyc_m  = cyc_m + 32'd1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("RegWriteW", 32'(RegWriteW), 32'(e_rw));
            check("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
            check("RD_W", 32'(RD_W), 32'(e_rd));
            check("PCPlus4W", PCPlus4W, e_pc);
            check("ALU_ResultW", ALU_ResultW, e_alu);
            if (e_rdata_v) check("ReadDataW", ReadDataW, e_rdata);
            check("misalign_err", 32'(misalign_err), 32'(mis_m));
            check("fault_state", 32'(fault_state), 32'(faulted_m));
            check("fault_count", 32'(fault_count), sat(onsets_m, 255));
            check("fault_cycle", fault_cycle, fcyc_m);
            check("parity_err_W", 32'(parity_err_W), 32'(e_perr));
            check("sat_fault_count", 32'(s_fault_count), sat(onsets_m, 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic mw, input logic rs,
                         input logic [31:0] addr, input logic [31:0] wd, input logic f);
        rst                    = r;
        MemWriteM              = mw;
        ResultSrcM             = rs;
        ALU_ResultM            = addr;
        WriteDataM             = wd;
        hardware_fault_flag_in = f;
        RegWriteM              = 1'($urandom_range(0, 1));
        RD_M                   = 5'($urandom);
        PCPlus4M               = $urandom;
        $display("txn rst=%0b we=%0b rs=%0b addr=%h wd=%h flag=%0b", r, mw, rs, addr, wd, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic        fl;
        checks = 0;
        errors = 0;

        // Reset with a store and a raised flag presented: nothing may happen.
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b1);
        check("rst_ReadDataW", ReadDataW, 32'h0);
        check("rst_fault_count", 32'(fault_count), 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);

        // Fill memory; fault flag high in cycles 100, 101 and 200 after reset.
        for (int k = 0; k < 1100; k++) begin
            drive(1'b1, k < DEPTH, 1'b0, 32'(k * 4), $urandom,
                  (k == 100) || (k == 101) || (k == 200));
        end
        check("onset_fault_count", 32'(fault_count), 32'd2);
        check("onset_fault_state", 32'(fault_state), 32'd1);
        check("onset_fault_cycle", fault_cycle, 32'd100);

        // Store then load.
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
        check("load_deadbeef", ReadDataW, 32'hDEADBEEF);
        check("load_resultsrc", 32'(ResultSrcW), 32'd1);

        // Read-during-write returns old data.
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h5, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h1, 1'b0);
        check("rdw_old", ReadDataW, 32'h5);
        drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
        check("rdw_new", ReadDataW, 32'h1);

        // Misaligned store is blocked and flagged.
        drive(1'b1, 1'b1, 1'b0, 32'h13, 32'h0BAD_F00D, 1'b0);
        check("misalign_set", 32'(misalign_err), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
        check("misalign_nowrite", ReadDataW, 32'hDEADBEEF);
        check("misalign_held", 32'(misalign_err), 32'd1);

        // Known word for the reset-during-store test.
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0);

        // Five separate pulses: narrow counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        check("sat_count_3", 32'(s_fault_count), 32'd3);
        check("full_count_7", 32'(fault_count), 32'd7);
        check("fault_cycle_kept", fault_cycle, 32'd100);

        // Randomised traffic on words 0..15 with random upper (wrapping) bits.
        fl = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            a = $urandom;
            a[11:6] = 6'd0;
            a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 15) == 0) fl = ~fl;
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, fl);
        end

`ifdef MEM_PARITY_EN
        // Corrupt one stored parity bit, then load it.
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0000_0003, 1'b0);
        dut.u_mem.par_q[32] = ~dut.u_mem.par_q[32];
        par_bad[32] = 1;
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 1'b0);
        check("parity_err_set", 32'(parity_err_W), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h84, 32'h0, 1'b0);
        check("parity_err_clear", 32'(parity_err_W), 32'd0);
`endif

        // Reset during a store: store dropped, outputs cleared.
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 1'b1);
        check("rst_store_ReadDataW", ReadDataW, 32'h0);
        check("rst_store_misalign", 32'(misalign_err), 32'h0);
        check("rst_store_fault_state", 32'(fault_state), 32'h0);
        check("rst_store_fault_cycle", fault_cycle, 32'h0);
        check("rst_store_RegWriteW", 32'(RegWriteW), 32'h0);

        // Flag already high as reset releases: onset in cycle 0.
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
        check("rst_store_dropped", ReadDataW, 32'hCAFE_F00D);
        check("early_onset_count", 32'(fault_count), 32'd1);
        check("early_onset_cycle", fault_cycle, 32'd0);
        check("early_onset_state", 32'(fault_state), 32'd1);

        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
